// File: rtl/div_clock_monitor_if.sv
// ============================================================================
// Module  : div_clock_monitor_if
// Brief   : Handshake bundle between the divided-clock monitor and its user.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_clock_monitor_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             div_in;
  logic             clear_err;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             error;

  modport master (
    output enable, div_in, clear_err,
    input  edge_pulse, period, period_valid, locked, error
  );

  modport slave (
    input  enable, div_in, clear_err,
    output edge_pulse, period, period_valid, locked, error
  );
endinterface

`default_nettype wire

// File: rtl/div_clock_monitor.sv
// ============================================================================
// Module  : div_clock_monitor
// Brief   : Synchronizes a divided clock, measures its period in clk cycles,
//           tracks lock against EXP_PERIOD +/- TOL and flags sticky errors.
//           Optional duty check: define DIV_CLOCK_MONITOR_DUTY_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_clock_monitor #(
  parameter int EXP_PERIOD = 32,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  div_clock_monitor_if.slave  mon
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_TRACK  = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam int              GOOD_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
  localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_COUNT);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic              s1;
  logic              s2;
  logic              s3;
  logic              edge_pulse;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_diff;
  logic              period_ok;
  logic              in_tol;
  logic              timeout;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_inc;
  logic [GOOD_W-1:0] good_next;
  logic              period_load;
  logic              err_set;
  logic              locked;
  logic [CNT_W-1:0]  period_reg;
  logic              period_valid_reg;
  logic              error_reg;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon.div_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

  // cnt reads P in the edge cycle that closes a period of P cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!mon.enable || state == ST_IDLE) begin
      cnt <= '0;
    end else if (edge_pulse) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout     = (cnt == CNT_MAX);
  assign period_diff = (cnt >= EXP_C) ? (cnt - EXP_C) : (EXP_C - cnt);
  assign period_ok   = (period_diff <= TOL_C);

`ifdef DIV_CLOCK_MONITOR_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(EXP_PERIOD / 2);

  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_diff;

  // s2 only rises through an edge, so counting while s2 is high after the
  // reload captures the high time up to the first low sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_cnt <= '0;
    end else if (!mon.enable || state == ST_IDLE) begin
      hi_cnt <= '0;
    end else if (edge_pulse) begin
      hi_cnt <= CNT_W'(1);
    end else if (s2 && hi_cnt != CNT_MAX) begin
      hi_cnt <= hi_cnt + 1'b1;
    end
  end

  assign hi_diff = (hi_cnt >= HALF_C) ? (hi_cnt - HALF_C) : (HALF_C - hi_cnt);
  assign in_tol  = period_ok && (hi_diff <= TOL_C);
`else
  assign in_tol  = period_ok;
`endif

  assign good_inc = good + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!mon.enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   next_state = ST_WAIT;
        ST_WAIT:   if (edge_pulse) next_state = ST_TRACK;
        ST_TRACK: begin
          if (edge_pulse) begin
            if (in_tol && good_inc == LOCK_C) next_state = ST_LOCKED;
          end else if (timeout) begin
            next_state = ST_WAIT;
          end
        end
        ST_LOCKED: begin
          if (edge_pulse) begin
            if (!in_tol) next_state = ST_TRACK;
          end else if (timeout) begin
            next_state = ST_WAIT;
          end
        end
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    period_load = 1'b0;
    err_set     = 1'b0;
    good_next   = good;
    locked      = (state == ST_LOCKED);
    if (!mon.enable) begin
      good_next = '0;
    end else begin
      case (state)
        ST_IDLE: good_next = '0;
        ST_WAIT: if (edge_pulse) good_next = '0;
        ST_TRACK: begin
          if (edge_pulse) begin
            period_load = 1'b1;
            good_next   = in_tol ? good_inc : '0;
          end else if (timeout) begin
            good_next = '0;
          end
        end
        ST_LOCKED: begin
          if (edge_pulse) begin
            period_load = 1'b1;
            if (!in_tol) begin
              err_set   = 1'b1;
              good_next = '0;
            end
          end else if (timeout) begin
            err_set   = 1'b1;
            good_next = '0;
          end
        end
        default: good_next = '0;
      endcase
    end
  end

  // A new fault wins over a simultaneous clear request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good             <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      good             <= good_next;
      period_valid_reg <= period_load;
      if (period_load) period_reg <= cnt;
      if (err_set) begin
        error_reg <= 1'b1;
      end else if (mon.clear_err) begin
        error_reg <= 1'b0;
      end
    end
  end

  assign mon.edge_pulse   = edge_pulse;
  assign mon.period       = period_reg;
  assign mon.period_valid = period_valid_reg;
  assign mon.locked       = locked;
  assign mon.error        = error_reg;

endmodule

`default_nettype wire

// File: tb/tb_div_clock_monitor.sv
// ============================================================================
// Module  : tb_div_clock_monitor
// Brief   : Directed, table-driven bench for div_clock_monitor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_clock_monitor;

  typedef struct {
    int hi;
    int lo;
    bit clr;
    bit exp_valid;
    int exp_period;
    bit exp_locked;
    bit exp_error;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests;
  int   n_fail;
  vec_t vecs[18];

  always #5 clk = ~clk;

  div_clock_monitor_if #(.CNT_W(8)) mon ();

  div_clock_monitor #(
    .EXP_PERIOD(32),
    .TOL(1),
    .LOCK_COUNT(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mon(mon)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Raises div_in now, holds hi cycles high then lo low; the edge pulse shows
  // two cycles after the raise and the registered results one cycle later
  task automatic run_period(input int hi, input int lo, input bit clr,
                            input bit ev, input int ep, input bit el,
                            input bit ee, input string tag);
    mon.div_in = 1'b1;
    for (int i = 1; i <= hi + lo; i++) begin
      cyc();
      if (i == 2) begin
        check({tag, " edge_pulse"}, 32'(mon.edge_pulse), 32'd1);
        if (clr) mon.clear_err = 1'b1;
      end
      if (i == 3) begin
        mon.clear_err = 1'b0;
        check({tag, " edge_pulse width"}, 32'(mon.edge_pulse), 32'd0);
        check({tag, " period_valid"}, 32'(mon.period_valid), 32'(ev));
        check({tag, " period"}, 32'(mon.period), 32'(ep));
        check({tag, " locked"}, 32'(mon.locked), 32'(el));
        check({tag, " error"}, 32'(mon.error), 32'(ee));
      end
      if (i == 4) check({tag, " period_valid width"}, 32'(mon.period_valid), 32'd0);
      if (i == hi) mon.div_in = 1'b0;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //          hi  lo clr val per lck err
    vecs[0]  = '{16, 16, 0, 0,  0, 0, 0};
    vecs[1]  = '{16, 16, 0, 1, 32, 0, 0};
    vecs[2]  = '{16, 16, 0, 1, 32, 0, 0};
    vecs[3]  = '{16, 16, 0, 1, 32, 0, 0};
    vecs[4]  = '{16, 15, 0, 1, 32, 1, 0};
    vecs[5]  = '{16, 17, 0, 1, 31, 1, 0};
    vecs[6]  = '{20, 15, 0, 1, 33, 1, 0};
    vecs[7]  = '{16, 16, 0, 1, 35, 0, 1};
    vecs[8]  = '{16, 16, 0, 1, 32, 0, 1};
    vecs[9]  = '{16, 16, 0, 1, 32, 0, 1};
    vecs[10] = '{16, 16, 0, 1, 32, 0, 1};
    vecs[11] = '{16, 16, 0, 1, 32, 1, 1};
    vecs[12] = '{16, 24, 0, 1, 32, 1, 1};
    vecs[13] = '{16, 16, 1, 1, 40, 0, 1};
    vecs[14] = '{16, 16, 1, 1, 32, 0, 0};
    vecs[15] = '{16, 16, 0, 1, 32, 0, 0};
    vecs[16] = '{16, 16, 0, 1, 32, 0, 0};
    vecs[17] = '{16, 16, 0, 1, 32, 1, 0};

    reset         = 1'b1;
    mon.enable    = 1'b0;
    mon.div_in    = 1'b0;
    mon.clear_err = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mon.div_in = (c % 4) >= 2;
      cyc();
    end
    check("reset edge_pulse", 32'(mon.edge_pulse), 32'd0);
    check("reset period", 32'(mon.period), 32'd0);
    check("reset period_valid", 32'(mon.period_valid), 32'd0);
    check("reset locked", 32'(mon.locked), 32'd0);
    check("reset error", 32'(mon.error), 32'd0);

    reset = 1'b0;
    for (int c = 0; c < 48; c++) begin
      mon.div_in = (c % 16) < 8;
      cyc();
      check("disabled outputs",
            {21'd0, mon.period_valid, mon.locked, mon.error, mon.period}, 32'd0);
    end
    mon.div_in = 1'b0;
    repeat (4) cyc();
    mon.enable = 1'b1;
    cyc();

    for (int r = 0; r < 18; r++) begin
      run_period(vecs[r].hi, vecs[r].lo, vecs[r].clr, vecs[r].exp_valid,
                 vecs[r].exp_period, vecs[r].exp_locked, vecs[r].exp_error,
                 $sformatf("row%0d", r));
    end

    // Stuck-low input while locked: timeout 255 cycles after the last edge
    for (int n = 1; n <= 226; n++) begin
      cyc();
      if (n == 225) begin
        check("pre-timeout locked", 32'(mon.locked), 32'd1);
        check("pre-timeout error", 32'(mon.error), 32'd0);
      end
      if (n == 226) begin
        check("timeout locked", 32'(mon.locked), 32'd0);
        check("timeout error", 32'(mon.error), 32'd1);
      end
    end
    run_period(16, 16, 1'b0, 1'b0, 32, 1'b0, 1'b1, "rewait");

    #3;
    reset = 1'b1;
    #1;
    check("async reset error", 32'(mon.error), 32'd0);
    check("async reset period", 32'(mon.period), 32'd0);
    check("async reset locked", 32'(mon.locked), 32'd0);
    check("async reset period_valid", 32'(mon.period_valid), 32'd0);
    cyc();
    reset = 1'b0;

`ifdef DIV_CLOCK_MONITOR_DUTY_CHECK_EN
    cyc();
    for (int p = 0; p < 6; p++) begin
      run_period(20, 12, 1'b0, p != 0, (p != 0) ? 32 : 0, 1'b0, 1'b0,
                 $sformatf("duty20_%0d", p));
    end
    for (int p = 0; p < 5; p++) begin
      run_period(16, 16, 1'b0, 1'b1, 32, p == 4, 1'b0,
                 $sformatf("duty16_%0d", p));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_clock_monitor.md
# div_clock_monitor

Synchronous monitor for the divided clock produced by the ripple T-flip-flop divider chain. It synchronizes the asynchronous divided signal into the system `clk` domain and detects its rising edges. It measures each period in `clk` cycles, checks it against the expected division ratio, and reports lock and sticky error status. It sits beside the divider, observing the divider output for consumers and for self-test.

## Interface

Parameters:
- `EXP_PERIOD`, default 32: expected period of `div_in`, in `clk` cycles (divide-by-32).
- `TOL`, default 1: accepted deviation, ± cycles.
- `LOCK_COUNT`, default 4: consecutive in-tolerance periods needed to assert `locked`.
- `CNT_W`, default 8: width of the period counter; the timeout is reached when the counter equals 2^CNT_W−1.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  monitor enable.
- `div_in`  in  1  divided clock, asynchronous to `clk`.
- `clear_err`  in  1  clears the sticky `error` flag.
- `edge_pulse`  out  1  one-cycle pulse per synchronized rising edge of `div_in`.
- `period`  out  CNT_W  last measured period.
- `period_valid`  out  1  one-cycle strobe; `period` has just been updated.
- `locked`  out  1  period stable within tolerance.
- `error`  out  1  sticky fault flag (mismatch or timeout).

## Operation

**Reset and synchronization**
- On `reset`, all outputs are 0, all registers are 0, and the state is IDLE.
- `div_in` passes through a 2-FF synchronizer (`s1`, `s2`) into a history register `s3`.
- `edge_pulse = s2 & ~s3`.

**Counter `cnt`**
- In IDLE, `cnt` holds 0.
- Otherwise, on an `edge_pulse` cycle, `cnt` is loaded with 1.
- Otherwise, `cnt` increments and saturates at 2^CNT_W−1.
- For edges P cycles apart, `cnt` equals P in the second edge cycle.

**FSM**
- IDLE → WAIT_EDGE when `enable` = 1.
- WAIT_EDGE → TRACK on the first `edge_pulse`; `good` is cleared and no `period_valid` is issued.
- TRACK, on `edge_pulse`:
  - `period` ← `cnt` and `period_valid` pulses.
  - If in tolerance, `good` ← `good`+1; when `good`+1 = LOCK_COUNT, go to LOCKED.
  - If out of tolerance, `good` ← 0 and stay in TRACK.
- LOCKED, on `edge_pulse`:
  - `period` ← `cnt` and `period_valid` pulses.
  - If out of tolerance, set `error` and go to TRACK with `good` = 0.
- Timeout (`cnt` saturated):
  - From TRACK → WAIT_EDGE, `good` = 0, no error.
  - From LOCKED → WAIT_EDGE and set `error`.
- `enable` = 0 in any state → IDLE next cycle; `cnt` and `good` are cleared and `error` is retained.

**Outputs and rules**
- `locked` = 1 exactly while the state is LOCKED.
- In tolerance means |`cnt` − EXP_PERIOD| ≤ TOL, using unsigned compare of both orderings with no wrap.
- `error`: set has priority over `clear_err` in the same cycle; `clear_err` alone clears it next cycle.

## Timing

- A rising edge of `div_in` produces `edge_pulse` 2–3 `clk` cycles later, depending on the sampling phase.
- `period`, `period_valid`, state and `locked`/`error` update at the clock edge that ends the `edge_pulse` cycle, so they are visible 1 cycle after `edge_pulse`.
- `period_valid` is exactly one cycle wide.
- Timeout fires in the cycle in which `cnt` first reads 2^CNT_W−1; with the defaults, that is 255 cycles after the last edge.
- Asserting `reset` mid-operation forces all outputs to 0 immediately, with no clock edge required.

## Configuration

- `DIV_CLOCK_MONITOR_DUTY_CHECK_EN`, when defined:
  - A high-time counter runs from the rising edge to the first cycle with `s2` = 0.
  - A period counts as in tolerance only if the period check passes **and** |high_time − EXP_PERIOD/2| ≤ TOL.
- When undefined, duty cycle is ignored and no high-time logic is built.

## Test plan

1. Reset asserted with `div_in` toggling → all outputs 0; after release with `enable` = 0, outputs stay 0.
2. `enable` = 1, 16-high/16-low square wave → first edge gives no `period_valid`; subsequent edges give `period` = 32; `locked` rises one cycle after the 5th `edge_pulse`.
3. While locked, periods 31 and 33 → `locked` stays 1 and `error` stays 0; then one period of 35 → `period` = 35, `error` = 1, `locked` = 0, and lock is regained after 4 good periods.
4. While locked, `div_in` stuck low → 255 cycles after the last edge, `error` = 1, `locked` = 0, state WAIT_EDGE.
5. `clear_err` pulsed in the same cycle as a mismatch → `error` stays 1; `clear_err` pulsed alone next → `error` = 0.
6. With `DIV_CLOCK_MONITOR_DUTY_CHECK_EN`: 20-high/12-low at period 32 → `locked` never asserts; 16/16 → `locked` after 4 periods.
